// File: rtl/i2c_req_arbiter_pkg.sv
// Shared definitions for the two-port I2C request arbiter: FSM encoding,
// watchdog defaults, port indices and the command record held for the driver.
package i2c_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam int TIMEOUT_CYC_DEF = 4095;
  localparam int TMO_W_DEF       = 12;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic        rh_wl;
    logic        bit_ctrl;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } i2c_cmd_t;

  // Writes return no data; the requester sees zero instead of a stale driver byte.
  function automatic logic [7:0] rd_result(input logic rh_wl, input logic [7:0] drv_byte);
    return rh_wl ? drv_byte : 8'h00;
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_pick2.sv
// Two-input round-robin selector: a lone requester wins outright, a tie goes to
// the port that did not win last time. Reusable for any two-master shared bus.
module i2c_rr_pick2
  import i2c_req_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       idx_o
);

  always_comb begin
    idx_o = PORT0;
    case (valid_i)
      2'b01:   idx_o = PORT0;
      2'b10:   idx_o = PORT1;
      2'b11:   idx_o = ~last_grant_i;
      default: idx_o = PORT0;
    endcase
  end

  always_comb begin
    grant_o = 2'b00;
    if (|valid_i) begin
      grant_o = (idx_o == PORT1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master driver between two single-byte EEPROM requesters,
// serialising them round-robin and guarding each transfer with a watchdog.
module i2c_req_arbiter
  import i2c_req_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TMO_W       = TMO_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  input  logic        req0_rh_wl,
  input  logic        req0_bit_ctrl,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [7:0]  req0_rdata,
  output logic        req0_err,

  input  logic        req1_valid,
  input  logic        req1_rh_wl,
  input  logic        req1_bit_ctrl,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [7:0]  req1_rdata,
  output logic        req1_err,

  output logic        drv_enable,
  output logic        drv_rh_wl,
  output logic        drv_bit_ctrl,
  output logic [15:0] drv_addr,
  output logic [7:0]  drv_wdata,
  input  logic [7:0]  drv_rdata,
  input  logic        drv_done,

  output logic        fault
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);

  arb_state_e       state_q;
  logic             owner_q;
  logic             last_grant_q;
  logic             fault_q;
  logic             drv_enable_q;
  logic [TMO_W-1:0] wdog_q;
  i2c_cmd_t         cmd_q;
  logic [1:0]       done_q;
  logic [1:0]       err_q;
  logic [7:0]       rdata_q [2];

  logic [1:0]       req_valid;
  logic [1:0]       grant;
  logic             pick_idx;
  logic             accept;
  i2c_cmd_t         cmd_sel;

  assign req_valid = {req1_valid, req0_valid};

  i2c_rr_pick2 u_pick (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .idx_o        (pick_idx)
  );

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  assign accept     = rst_n & ~fault_q & (state_q == ST_IDLE) & (|req_valid);
  assign req0_ready = accept & grant[PORT0];
  assign req1_ready = accept & grant[PORT1];

  assign cmd_sel = (pick_idx == PORT1)
                 ? {req1_rh_wl, req1_bit_ctrl, req1_addr, req1_wdata}
                 : {req0_rh_wl, req0_bit_ctrl, req0_addr, req0_wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT0;
      last_grant_q <= PORT1;
      fault_q      <= 1'b0;
      drv_enable_q <= 1'b0;
      wdog_q       <= '0;
      cmd_q        <= '0;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      rdata_q[0]   <= 8'h00;
      rdata_q[1]   <= 8'h00;
    end else begin
      drv_enable_q <= 1'b0;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      rdata_q[0]   <= 8'h00;
      rdata_q[1]   <= 8'h00;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_q        <= cmd_sel;
            owner_q      <= pick_idx;
            last_grant_q <= pick_idx;
            drv_enable_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end

        // A done seen in the same cycle as the timeout limit still counts as success.
        ST_WAIT: begin
          if (drv_done) begin
            done_q[owner_q]  <= 1'b1;
            rdata_q[owner_q] <= rd_result(cmd_q.rh_wl, drv_rdata);
            state_q          <= ST_RELEASE;
          end else if (wdog_q == TMO_LIM) begin
            done_q[owner_q] <= 1'b1;
            err_q[owner_q]  <= 1'b1;
            fault_q         <= 1'b1;
            state_q         <= ST_RELEASE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (!drv_done) begin
            wdog_q  <= '0;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign drv_enable   = drv_enable_q;
  assign drv_rh_wl    = cmd_q.rh_wl;
  assign drv_bit_ctrl = cmd_q.bit_ctrl;
  assign drv_addr     = cmd_q.addr;
  assign drv_wdata    = cmd_q.wdata;

  assign req0_done  = done_q[PORT0];
  assign req0_err   = err_q[PORT0];
  assign req0_rdata = rdata_q[PORT0];
  assign req1_done  = done_q[PORT1];
  assign req1_err   = err_q[PORT1];
  assign req1_rdata = rdata_q[PORT1];

  assign fault = fault_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: a driver model, a transaction-level reference
// checked every cycle, a directed vector table and a randomized phase.
module tb_i2c_req_arbiter;

  localparam int TMO = 400;

  logic        clk;
  logic        rst_n;
  logic        vld [2];
  logic        rh  [2];
  logic        bc  [2];
  logic [15:0] ad  [2];
  logic [7:0]  wd  [2];
  logic        rdy [2];
  logic        dn  [2];
  logic        er  [2];
  logic [7:0]  rd  [2];
  logic        drv_enable, drv_rh_wl, drv_bit_ctrl, drv_done, fault;
  logic [15:0] drv_addr;
  logic [7:0]  drv_wdata, drv_rdata;

  i2c_req_arbiter #(.TIMEOUT_CYC(TMO), .TMO_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(vld[0]), .req0_rh_wl(rh[0]), .req0_bit_ctrl(bc[0]), .req0_addr(ad[0]),
    .req0_wdata(wd[0]), .req0_ready(rdy[0]), .req0_done(dn[0]), .req0_rdata(rd[0]), .req0_err(er[0]),
    .req1_valid(vld[1]), .req1_rh_wl(rh[1]), .req1_bit_ctrl(bc[1]), .req1_addr(ad[1]),
    .req1_wdata(wd[1]), .req1_ready(rdy[1]), .req1_done(dn[1]), .req1_rdata(rd[1]), .req1_err(er[1]),
    .drv_enable(drv_enable), .drv_rh_wl(drv_rh_wl), .drv_bit_ctrl(drv_bit_ctrl),
    .drv_addr(drv_addr), .drv_wdata(drv_wdata), .drv_rdata(drv_rdata), .drv_done(drv_done),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Driver model configuration
  int         cfg_lat  = 3;
  int         cfg_hold = 1;
  logic [7:0] cfg_rval = 8'h00;
  bit         cfg_never = 1'b0;
  bit         rnd_drv   = 1'b0;

  initial begin
    int lat, hold;
    logic [7:0] rv;
    bit ab;
    drv_done  = 1'b0;
    drv_rdata = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (rst_n && drv_enable) begin
        lat  = rnd_drv ? int'($urandom_range(1, 30)) : cfg_lat;
        hold = rnd_drv ? int'($urandom_range(1, 4))  : cfg_hold;
        rv   = rnd_drv ? 8'($urandom) : cfg_rval;
        ab   = 1'b0;
        if (cfg_never) begin
          while (rst_n) begin @(posedge clk); #2; end
          ab = 1'b1;
        end else begin
          for (int i = 0; i < lat; i++) begin
            @(posedge clk); #2;
            if (!rst_n) begin ab = 1'b1; break; end
          end
        end
        if (!ab) begin
          drv_done  = 1'b1;
          drv_rdata = rv;
          for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            if (!rst_n) break;
          end
        end
        drv_done  = 1'b0;
        drv_rdata = 8'h00;
      end
    end
  end

  // Transaction-level reference
  bit          m_busy = 1'b0, m_fault = 1'b0, m_err = 1'b0, m_last = 1'b1;
  int          m_owner = 0, en_cyc = -1, done_cyc = -1;
  logic [7:0]  m_rd = 8'h00;
  logic [25:0] m_cmd = '0;
  int          acc_cnt [2] = '{0, 0};
  int          done_cnt[2] = '{0, 0};
  logic [7:0]  last_rd [2];
  logic        last_er [2];
  int          gq[$];

  initial begin
    int w;
    bit ed;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_req_outs", {rdy[0], rdy[1], dn[0], dn[1], er[0], er[1], rd[0], rd[1], fault}, 64'h0);
        chk("reset_drv_outs", {drv_enable, drv_rh_wl, drv_bit_ctrl, drv_addr, drv_wdata}, 64'h0);
        m_busy = 0; m_fault = 0; m_last = 1; en_cyc = -1; done_cyc = -1;
      end else begin
        w = -1;
        if (!m_busy && !m_fault) begin
          if (vld[0] && vld[1]) w = m_last ? 0 : 1;
          else if (vld[0])      w = 0;
          else if (vld[1])      w = 1;
        end
        chk("ready0", rdy[0], w == 0);
        chk("ready1", rdy[1], w == 1);
        chk("drv_enable", drv_enable, cyc == en_cyc);
        if (m_busy && en_cyc >= 0 && cyc >= en_cyc)
          chk("drv_cmd", {drv_rh_wl, drv_bit_ctrl, drv_addr, drv_wdata}, m_cmd);
        if (cyc == done_cyc && m_err) m_fault = 1;
        for (int p = 0; p < 2; p++) begin
          ed = (cyc == done_cyc) && (m_owner == p);
          chk($sformatf("done%0d", p), dn[p], ed);
          chk($sformatf("err%0d", p), er[p], ed ? m_err : 1'b0);
          chk($sformatf("rdata%0d", p), rd[p], ed ? m_rd : 8'h00);
          if (dn[p] === 1'b1) begin
            done_cnt[p]++;
            last_rd[p] = rd[p];
            last_er[p] = er[p];
          end
        end
        chk("fault", fault, m_fault);
        if (m_busy && done_cyc < 0 && en_cyc >= 0 && cyc > en_cyc) begin
          if (drv_done) begin
            done_cyc = cyc + 1; m_err = 0;
            m_rd = m_cmd[25] ? drv_rdata : 8'h00;
          end else if (cyc == en_cyc + TMO + 1) begin
            done_cyc = cyc + 1; m_err = 1; m_rd = 8'h00;
          end
        end
        if (m_busy && done_cyc >= 0 && cyc >= done_cyc && !drv_done) m_busy = 0;
        if (w >= 0) begin
          acc_cnt[w]++;
          gq.push_back(w);
          m_busy = 1; m_owner = w; m_last = (w == 1);
          en_cyc = cyc + 1; done_cyc = -1;
          m_cmd = {rh[w], bc[w], ad[w], wd[w]};
        end
      end
    end
  end

  task automatic send(input int p, input logic r, input logic b, input logic [15:0] a, input logic [7:0] d);
    int a0;
    bit ok;
    @(posedge clk); #1;
    rh[p] = r; bc[p] = b; ad[p] = a; wd[p] = d; vld[p] = 1'b1;
    a0 = acc_cnt[p];
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (acc_cnt[p] != a0) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    vld[p] = 1'b0;
    chk($sformatf("accept_seen%0d", p), ok, 1'b1);
  endtask

  task automatic wait_done(input int p, input int lim);
    int d0;
    bit ok;
    d0 = done_cnt[p];
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if (done_cnt[p] != d0) begin ok = 1'b1; break; end
    end
    chk($sformatf("done_seen%0d", p), ok, 1'b1);
  endtask

  task automatic wait_grants(input int n);
    for (int i = 0; i < 500 && gq.size() < n; i++) begin @(negedge clk); #1; end
    chk("grant_count", gq.size() >= n, 1'b1);
  endtask

  typedef struct {
    int          port;
    logic        rh;
    logic        bc;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          lat;
    int          hold;
    logic [7:0]  drv_rd;
    logic [7:0]  exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int a0;
    int seen[2];
    tbl[0] = '{0, 1'b0, 1'b0, 16'h0012, 8'hA5, 300, 1,  8'h00, 8'h00, 1'b0};
    tbl[1] = '{1, 1'b1, 1'b0, 16'h0034, 8'h00, 20,  1,  8'h5C, 8'h5C, 1'b0};
    tbl[2] = '{0, 1'b1, 1'b1, 16'h1234, 8'h00, 5,   16, 8'h77, 8'h77, 1'b0};
    tbl[3] = '{1, 1'b0, 1'b1, 16'hBEEF, 8'h3C, 1,   2,  8'h99, 8'h00, 1'b0};
    tbl[4] = '{0, 1'b1, 1'b0, 16'h00FF, 8'h00, 1,   1,  8'hA3, 8'hA3, 1'b0};

    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      vld[p] = 1'b0; rh[p] = 1'b0; bc[p] = 1'b0; ad[p] = 16'h0; wd[p] = 8'h0;
    end

    // Contention from reset: both ports held valid
    repeat (3) @(posedge clk);
    #1;
    rh[0] = 1'b0; ad[0] = 16'h0010; wd[0] = 8'h11; vld[0] = 1'b1;
    rh[1] = 1'b1; ad[1] = 16'h0020; wd[1] = 8'h22; vld[1] = 1'b1;
    cfg_rval = 8'h11;
    rst_n = 1'b1;
    wait_grants(3);
    @(posedge clk); #1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    chk("contention_first",  gq[0], 0);
    chk("contention_second", gq[1], 1);
    chk("contention_third",  gq[2], 0);
    repeat (30) @(posedge clk);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      cfg_lat = tbl[i].lat; cfg_hold = tbl[i].hold; cfg_rval = tbl[i].drv_rd;
      send(tbl[i].port, tbl[i].rh, tbl[i].bc, tbl[i].addr, tbl[i].wdata);
      wait_done(tbl[i].port, 1000);
      chk($sformatf("vec%0d_rdata", i), last_rd[tbl[i].port], tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), last_er[tbl[i].port], tbl[i].exp_err);
      repeat (25) @(posedge clk);
    end

    // Randomized traffic
    rnd_drv = 1'b1;
    seen[0] = acc_cnt[0]; seen[1] = acc_cnt[1];
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (vld[p]) begin
          if (acc_cnt[p] != seen[p]) begin
            seen[p] = acc_cnt[p];
            vld[p] = 1'($urandom_range(0, 1));
            rh[p] = 1'($urandom); bc[p] = 1'($urandom); ad[p] = 16'($urandom); wd[p] = 8'($urandom);
          end else if ($urandom_range(0, 39) == 0) begin
            vld[p] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          rh[p] = 1'($urandom); bc[p] = 1'($urandom); ad[p] = 16'($urandom); wd[p] = 8'($urandom);
          vld[p] = 1'b1;
        end
      end
    end
    vld[0] = 1'b0; vld[1] = 1'b0;
    repeat (60) @(posedge clk);
    rnd_drv = 1'b0;
    chk("rnd_accepts_vs_dones", acc_cnt[0] + acc_cnt[1], done_cnt[0] + done_cnt[1]);
    chk("rnd_activity", (acc_cnt[0] > 20) && (acc_cnt[1] > 20), 1'b1);

    // Reset in the middle of WAIT
    cfg_lat = 200; cfg_hold = 1; cfg_rval = 8'h42;
    send(0, 1'b1, 1'b0, 16'h0055, 8'h00);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midwait_reset_outs", {rdy[0], rdy[1], dn[0], dn[1], drv_enable, fault}, 64'h0);
    @(posedge clk); #1;
    cfg_lat = 3;
    gq.delete();
    vld[0] = 1'b1; vld[1] = 1'b1;
    rst_n = 1'b1;
    wait_grants(1);
    @(posedge clk); #1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    chk("post_reset_winner", gq[0], 0);
    wait_done(0, 100);
    repeat (10) @(posedge clk);

    // Watchdog timeout and sticky fault
    cfg_never = 1'b1;
    send(0, 1'b1, 1'b0, 16'h0040, 8'h00);
    wait_done(0, TMO + 50);
    chk("tmo_err0", last_er[0], 1'b1);
    chk("tmo_rdata0", last_rd[0], 8'h00);
    chk("tmo_fault", fault, 1'b1);
    a0 = acc_cnt[1];
    @(posedge clk); #1;
    vld[1] = 1'b1; rh[1] = 1'b0; ad[1] = 16'h0077; wd[1] = 8'h5A;
    repeat (60) @(posedge clk);
    chk("fault_blocks_req1", acc_cnt[1], a0);
    chk("fault_still_set", fault, 1'b1);
    #1;
    rst_n = 1'b0;
    cfg_never = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("fault_cleared", fault, 1'b0);
    for (int i = 0; i < 50 && acc_cnt[1] == a0; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    vld[1] = 1'b0;
    chk("req1_after_reset", acc_cnt[1], a0 + 1);
    wait_done(1, 100);
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: reached cycle %0d without finishing, required end before cycle 80000", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
